adma_descriptor_fetch: RTL
==========================

Name: adma_descriptor_fetch

Overview:
- Upstream feeder of the ADMA transfer state machine.
- Owns the descriptor pointer and reads 64-bit ADMA2 descriptors from system memory over a 32-bit read port, two beats per descriptor.
- Decodes each descriptor and presents it with a valid/ack handshake.
- Loaded by command_reg_write/starting_address; advances sequentially, or jumps on LINK descriptors.

Parameters:
- ADDR_W, 64, descriptor pointer and memory address width
- DESC_BYTES, 8, pointer increment per descriptor

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- STOP  in  1  abort; returns to IDLE next edge, pointer retained
- command_reg_write  in  1  pulse; loads pointer from starting_address
- starting_address  in  64  descriptor table base
- fetch_req  in  1  state machine requests next descriptor (level, sampled in IDLE)
- desc_ack  in  1  consumer accepts presented descriptor
- mem_req  out  1  memory read request, held until mem_ack
- mem_addr  out  64  read address (stable while mem_req)
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  32  read data
- mem_err  in  1  bus error, qualified by mem_ack
- desc_valid  out  1  descriptor fields valid, held until desc_ack
- desc_address  out  32  data buffer address (bits 63:32)
- desc_length  out  17  byte count; field 0 decodes to 65536
- desc_end  out  1  bit 1
- desc_int  out  1  bit 2
- desc_act  out  2  bits 5:4: 00 NOP, 01 RSV, 10 TRAN, 11 LINK
- fetch_error  out  1  sticky error flag; cleared by command_reg_write
- busy  out  1  high in any state except IDLE and ERROR
- desc_pointer  out  64  current pointer

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, pointer 0. All outputs 0: mem_req, mem_addr, desc_*, fetch_error, busy.
- States: IDLE, RD_LO, RD_HI, PRESENT, ERROR.
- IDLE:
  - command_reg_write loads pointer <= starting_address and clears fetch_error.
  - Otherwise, fetch_req with fetch_error=0 goes to RD_LO. If pointer[2:0]!=0, it goes to ERROR instead.
- RD_LO:
  - mem_req=1, mem_addr=pointer.
  - On mem_ack, latch rdata as low word and go to RD_HI. Go to ERROR instead if mem_err=1.
- RD_HI:
  - mem_req=1, mem_addr=pointer+4.
  - On mem_ack, latch rdata as high word. Go to ERROR if mem_err=1.
  - Else go to ERROR if valid bit (bit 0)=0 or act=01.
  - Else go to PRESENT.
- mem_req deasserts in the same cycle mem_ack is sampled (registered; low the cycle after the ack). No back-to-back beat without a 1-cycle gap.
- PRESENT:
  - desc_valid=1, fields stable.
  - On desc_ack: if act=LINK, pointer <= {32'b0, desc_address}; else pointer <= pointer+8 (mod 2^64, wraps silently). Return to IDLE; desc_valid drops next cycle.
- ERROR: fetch_error=1, desc_valid=0, mem_req=0. Exits only via command_reg_write (to IDLE) or reset.
- STOP has priority over every transition:
  - Goes to IDLE next edge.
  - mem_req and desc_valid drop.
  - A pending memory beat is abandoned; a late mem_ack in IDLE is ignored.
  - The pointer is not advanced.
- command_reg_write outside IDLE/ERROR is ignored (no pointer corruption mid-fetch).
- command_reg_write together with STOP: STOP wins the state change and the pointer load still occurs.
- desc_end/desc_int are reported only; the consumer decides on termination.
- Latency with zero-wait memory: fetch_req to desc_valid is 5 cycles (IDLE→RD_LO, ack, gap, RD_HI ack, PRESENT).

Decomposition:
- Shared defines:
  - state encodings
  - ACT codes (NOP/RSV/TRAN/LINK)
  - descriptor bit positions (VALID=0, END=1, INT=2, ACT=5:4, LEN=31:16, ADDR=63:32)
  - DESC_BYTES
- One natural sub-module, adma_desc_decode: combinational split of the 64-bit word into fields, length-0→65536 conversion, and an error flag. Everything else stays in the top.

Test Plan:
- Load starting_address=0x1000, fetch_req, memory returns lo=0x0200_0021, hi=0x8000_0000 (zero wait).
  Expected: reads at 0x1000 and 0x1004; desc_valid with act=10, length=0x0200, address=0x8000_0000, end=0. After desc_ack, desc_pointer=0x1008.
- LINK descriptor (lo=0x0000_0031, hi=0x0000_4000) at 0x1008.
  Expected: after ack desc_pointer=0x4000; next fetch reads 0x4000.
- Length field 0 with END (lo=0x0000_0023).
  Expected: desc_length=65536, desc_end=1.
- Invalid descriptor (lo bit0=0), and separately mem_err on the high beat.
  Expected: ERROR, fetch_error=1, busy=0, pointer unchanged. command_reg_write clears the flag.
- Misaligned start 0x1004 then fetch_req.
  Expected: no mem_req; fetch_error=1 next cycle.
- STOP asserted while RD_HI waits 3 cycles for ack.
  Expected: mem_req low next cycle, state IDLE, pointer unchanged, a late mem_ack is ignored. Also assert RESET low mid-PRESENT: all outputs 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/adma_descriptor_fetch_pkg.sv
// Shared definitions for the ADMA2 descriptor fetcher: states, ACT codes,
// descriptor bit layout and pointer stride.
package adma_descriptor_fetch_pkg;

    localparam int unsigned DESC_BYTES = 8;

    localparam int unsigned BIT_VALID = 0;
    localparam int unsigned BIT_END   = 1;
    localparam int unsigned BIT_INT   = 2;
    localparam int unsigned ACT_LSB   = 4;
    localparam int unsigned LEN_LSB   = 16;
    localparam int unsigned ADDR_LSB  = 32;

    typedef enum logic [1:0] {
        ACT_NOP  = 2'b00,
        ACT_RSV  = 2'b01,
        ACT_TRAN = 2'b10,
        ACT_LINK = 2'b11
    } act_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_PRESENT,
        ST_ERROR
    } fetch_state_t;

    // A zero length field means the maximum transfer of 64 KiB.
    function automatic logic [16:0] decode_length(input logic [15:0] field);
        return (field == 16'h0000) ? 17'h10000 : {1'b0, field};
    endfunction

endpackage

// File: rtl/adma_descriptor_fetch_if.sv
// Memory read port plus decoded-descriptor handshake of the descriptor fetcher.
interface adma_descriptor_fetch_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_err;

    logic              desc_valid;
    logic              desc_ack;
    logic [31:0]       desc_address;
    logic [16:0]       desc_length;
    logic              desc_end;
    logic              desc_int;
    logic [1:0]        desc_act;

    modport master (
        output mem_req, mem_addr, desc_valid, desc_address, desc_length,
               desc_end, desc_int, desc_act,
        input  mem_ack, mem_rdata, mem_err, desc_ack
    );

    modport slave (
        input  mem_req, mem_addr, desc_valid, desc_address, desc_length,
               desc_end, desc_int, desc_act,
        output mem_ack, mem_rdata, mem_err, desc_ack
    );
endinterface

// File: rtl/adma_desc_decode.sv
// Combinational split of a 64-bit ADMA2 descriptor into its fields,
// flagging invalid or reserved-action descriptors.
module adma_desc_decode
    import adma_descriptor_fetch_pkg::*;
(
    input  logic [63:0] word,
    output logic [31:0] address,
    output logic [16:0] length,
    output logic        end_flag,
    output logic        int_flag,
    output act_t        act,
    output logic        err
);
    logic unused_bits;

    assign address     = word[ADDR_LSB +: 32];
    assign length      = decode_length(word[LEN_LSB +: 16]);
    assign end_flag    = word[BIT_END];
    assign int_flag    = word[BIT_INT];
    assign act         = act_t'(word[ACT_LSB +: 2]);
    assign err         = !word[BIT_VALID] || (act == ACT_RSV);
    assign unused_bits = ^{word[15:6], word[3]};
endmodule

// File: rtl/adma_descriptor_fetch.sv
// ADMA2 descriptor fetcher: owns the descriptor pointer, reads each 64-bit
// descriptor as two 32-bit beats and presents the decoded fields.
module adma_descriptor_fetch #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DESC_BYTES = adma_descriptor_fetch_pkg::DESC_BYTES
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     STOP,
    input  logic                     command_reg_write,
    input  logic [ADDR_W-1:0]        starting_address,
    input  logic                     fetch_req,
    adma_descriptor_fetch_if.master  bus,
    output logic                     fetch_error,
    output logic                     busy,
    output logic [ADDR_W-1:0]        desc_pointer
);
    import adma_descriptor_fetch_pkg::*;

    fetch_state_t state;
    logic [31:0]  lo_word;
    logic [31:0]  dec_address;
    logic [16:0]  dec_length;
    logic         dec_end;
    logic         dec_int;
    act_t         dec_act;
    logic         dec_err;
    logic         beat_ack;
    logic         load_ptr;

    adma_desc_decode u_decode (
        .word     ({bus.mem_rdata, lo_word}),
        .address  (dec_address),
        .length   (dec_length),
        .end_flag (dec_end),
        .int_flag (dec_int),
        .act      (dec_act),
        .err      (dec_err)
    );

    // An ack only counts while our request is actually on the bus, so a late
    // ack after STOP or during the inter-beat gap is ignored.
    assign beat_ack = bus.mem_req && bus.mem_ack;
    assign load_ptr = command_reg_write &&
                      (STOP || state == ST_IDLE || state == ST_ERROR);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state            <= ST_IDLE;
            lo_word          <= '0;
            desc_pointer     <= '0;
            fetch_error      <= 1'b0;
            busy             <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_addr     <= '0;
            bus.desc_valid   <= 1'b0;
            bus.desc_address <= '0;
            bus.desc_length  <= '0;
            bus.desc_end     <= 1'b0;
            bus.desc_int     <= 1'b0;
            bus.desc_act     <= '0;
        end else begin
            if (load_ptr) begin
                desc_pointer <= starting_address;
                fetch_error  <= 1'b0;
            end
            if (STOP) begin
                state          <= ST_IDLE;
                bus.mem_req    <= 1'b0;
                bus.desc_valid <= 1'b0;
                busy           <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!command_reg_write && fetch_req && !fetch_error) begin
                            if (desc_pointer[2:0] != 3'b000) begin
                                state       <= ST_ERROR;
                                fetch_error <= 1'b1;
                            end else begin
                                state        <= ST_RD_LO;
                                bus.mem_req  <= 1'b1;
                                bus.mem_addr <= desc_pointer;
                                busy         <= 1'b1;
                            end
                        end
                    end
                    ST_RD_LO: begin
                        if (beat_ack) begin
                            bus.mem_req <= 1'b0;
                            if (bus.mem_err) begin
                                state       <= ST_ERROR;
                                fetch_error <= 1'b1;
                                busy        <= 1'b0;
                            end else begin
                                lo_word <= bus.mem_rdata;
                                state   <= ST_RD_HI;
                            end
                        end
                    end
                    ST_RD_HI: begin
                        // First cycle here is the mandatory gap between beats.
                        if (!bus.mem_req) begin
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= desc_pointer + ADDR_W'(4);
                        end else if (bus.mem_ack) begin
                            bus.mem_req <= 1'b0;
                            if (bus.mem_err || dec_err) begin
                                state       <= ST_ERROR;
                                fetch_error <= 1'b1;
                                busy        <= 1'b0;
                            end else begin
                                state            <= ST_PRESENT;
                                bus.desc_valid   <= 1'b1;
                                bus.desc_address <= dec_address;
                                bus.desc_length  <= dec_length;
                                bus.desc_end     <= dec_end;
                                bus.desc_int     <= dec_int;
                                bus.desc_act     <= dec_act;
                            end
                        end
                    end
                    ST_PRESENT: begin
                        if (bus.desc_ack) begin
                            state          <= ST_IDLE;
                            bus.desc_valid <= 1'b0;
                            busy           <= 1'b0;
                            if (bus.desc_act == ACT_LINK)
                                desc_pointer <= ADDR_W'(bus.desc_address);
                            else
                                desc_pointer <= desc_pointer + ADDR_W'(DESC_BYTES);
                        end
                    end
                    ST_ERROR: begin
                        if (command_reg_write)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
